// File: rtl/cp0_regfile_v2.sv
// ---------------------------------------------------------------------------
// cp0_regfile_v2
//   CP0 register file for the 5-stage MIPS core. It holds BadVAddr (8),
//   Count (9), Compare (11), Status (12), Cause (13) and EPC (14). It also
//   has a prescaled Count timer with a sticky timer interrupt, and it raises
//   a registered interrupt request towards the pipeline.
//
//   Optional build macro: CP0_IRQ_SYNC_EN
//     defined   : each hw_irq bit passes through a 2-flop synchronizer
//                 (hw_irq -> irq_pending latency is 3 cycles)
//     undefined : hw_irq is registered once (latency is 2 cycles)
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   wen/waddr/wdata                mtc0 write
//   raddr/rdata                    mfc0 read (combinational, no bypass)
//   exception, exc_code, exc_pc,
//   exc_bd, exc_badvaddr_vld,
//   exc_badvaddr                   exception commit
//   eret                           eret commit
//   hw_irq                         level-sensitive external interrupts
//   epc_out, status_exl            EPC and Status.EXL for the pipeline
//   irq_pending                    registered interrupt request
// ---------------------------------------------------------------------------
module cp0_regfile_v2 #(
  parameter int unsigned HW_IRQ_NUM  = 5,
  parameter int unsigned TIMER_DIV   = 2,
  parameter logic [31:0] COUNT_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wen,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic                  exception,
  input  logic                  eret,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  exc_badvaddr_vld,
  input  logic [31:0]           exc_badvaddr,
  input  logic [HW_IRQ_NUM-1:0] hw_irq,
  output logic [31:0]           epc_out,
  output logic                  status_exl,
  output logic                  irq_pending
);

  localparam logic [7:0]  PRESC_MAX    = 8'(TIMER_DIV - 1);
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  // Status bits that software may change: IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic        ti_q, ti_d;
  logic [7:0]  presc_q, presc_d;
  logic        irq_q, irq_d;
  logic [HW_IRQ_NUM-1:0] hw_q, hw_d;
`ifdef CP0_IRQ_SYNC_EN
  logic [HW_IRQ_NUM-1:0] hw_meta_q, hw_meta_d;
`endif

  logic [4:0]  ip_hw;
  logic [7:0]  ip;
  logic [31:0] cause;
  logic        do_eret;
  logic        do_wr;

  // Map the sampled lines onto IP[6:2]; lines beyond HW_IRQ_NUM read 0.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_ip_hw
      if (gi < HW_IRQ_NUM) begin : g_used
        assign ip_hw[gi] = hw_q[gi];
      end else begin : g_unused
        assign ip_hw[gi] = 1'b0;
      end
    end
  endgenerate

  assign ip    = {ti_q, ip_hw, ip_sw_q};
  assign cause = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b00};

  // Exception wins over eret, and eret wins over mtc0.
  assign do_eret = eret & ~exception;
  assign do_wr   = wen & ~exception & ~eret;

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    exccode_d  = exccode_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    presc_d    = presc_q;
`ifdef CP0_IRQ_SYNC_EN
    hw_meta_d  = hw_irq;
    hw_d       = hw_meta_q;
`else
    hw_d       = hw_irq;
`endif

    // Free-running timer; an mtc0 to Count below overrides this tick.
    if (presc_q == PRESC_MAX) begin
      presc_d = 8'd0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + 8'd1;
    end

    if (exception) begin
      // Nested exceptions (EXL already set) keep the original EPC and BD.
      if (!status_q[1]) begin
        epc_d = exc_pc;
        bd_d  = exc_bd;
      end
      status_d[1] = 1'b1;
      exccode_d   = exc_code;
      if (exc_badvaddr_vld) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (do_eret) begin
      status_d[1] = 1'b0;
    end else if (do_wr) begin
      case (waddr)
        5'd9: begin
          count_d = wdata;
          presc_d = 8'd0;
        end
        5'd11: compare_d = wdata;
        5'd12: status_d  = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        5'd13: ip_sw_d   = wdata[9:8];
        5'd14: epc_d     = wdata;
        default: ;
      endcase
    end

    // Sticky match on the post-update Count; an mtc0 to Compare clears it
    // and beats a coincident match.
    ti_d = ti_q | (count_d == compare_q);
    if (do_wr && (waddr == 5'd11)) begin
      ti_d = 1'b0;
    end

    irq_d = exception ? 1'b0
                      : ((|(ip & status_q[15:8])) & status_q[0] & ~status_q[1]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      badvaddr_q <= 32'h0;
      count_q    <= COUNT_RESET;
      compare_q  <= 32'h0;
      status_q   <= STATUS_RESET;
      epc_q      <= 32'h0;
      exccode_q  <= 5'h0;
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      ti_q       <= 1'b0;
      presc_q    <= 8'd0;
      irq_q      <= 1'b0;
      hw_q       <= '0;
`ifdef CP0_IRQ_SYNC_EN
      hw_meta_q  <= '0;
`endif
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      exccode_q  <= exccode_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ti_q       <= ti_d;
      presc_q    <= presc_d;
      irq_q      <= irq_d;
      hw_q       <= hw_d;
`ifdef CP0_IRQ_SYNC_EN
      hw_meta_q  <= hw_meta_d;
`endif
    end
  end

  // mfc0 read path: old register values, no write bypass.
  always_comb begin
    rdata = 32'h0;
    case (raddr)
      5'd8:    rdata = badvaddr_q;
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
      5'd12:   rdata = status_q;
      5'd13:   rdata = cause;
      5'd14:   rdata = epc_q;
      default: rdata = 32'h0;
    endcase
  end

  assign epc_out     = epc_q;
  assign status_exl  = status_q[1];
  assign irq_pending = irq_q;

endmodule

// File: tb/tb_cp0_regfile_v2.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile_v2
//   Self-checking bench for cp0_regfile_v2. A behavioural model tracks the
//   architectural CP0 state (Count is derived from cycles since the last
//   load). Every falling edge compares rdata, epc_out, status_exl and
//   irq_pending with the model. Directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_cp0_regfile_v2;

  localparam int unsigned HW_IRQ_NUM  = 5;
  localparam int unsigned TIMER_DIV   = 2;
  localparam logic [31:0] COUNT_RESET = 32'h0;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  wen;
  logic [4:0]            waddr;
  logic [31:0]           wdata;
  logic [4:0]            raddr;
  logic [31:0]           rdata;
  logic                  exception;
  logic                  eret;
  logic [4:0]            exc_code;
  logic [31:0]           exc_pc;
  logic                  exc_bd;
  logic                  exc_badvaddr_vld;
  logic [31:0]           exc_badvaddr;
  logic [HW_IRQ_NUM-1:0] hw_irq;
  logic [31:0]           epc_out;
  logic                  status_exl;
  logic                  irq_pending;

  int errors = 0;
  int checks = 0;

  cp0_regfile_v2 #(
    .HW_IRQ_NUM (HW_IRQ_NUM),
    .TIMER_DIV  (TIMER_DIV),
    .COUNT_RESET(COUNT_RESET)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .wen             (wen),
    .waddr           (waddr),
    .wdata           (wdata),
    .raddr           (raddr),
    .rdata           (rdata),
    .exception       (exception),
    .eret            (eret),
    .exc_code        (exc_code),
    .exc_pc          (exc_pc),
    .exc_bd          (exc_bd),
    .exc_badvaddr_vld(exc_badvaddr_vld),
    .exc_badvaddr    (exc_badvaddr),
    .hw_irq          (hw_irq),
    .epc_out         (epc_out),
    .status_exl      (status_exl),
    .irq_pending     (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_base, m_count, m_compare, m_status, m_epc, m_badv;
  int unsigned m_cyc;
  logic [4:0]  m_code, m_ip_hw, m_stage, hwp;
  logic        m_bd, m_ti, m_irq, m_started, nirq, clr;
  logic [1:0]  m_sw;
  logic [7:0]  ipv;
  logic [31:0] cnt;

  initial m_started = 1'b0;

  function automatic logic [7:0] m_ip();
    return {m_ti, m_ip_hw, m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] c;
    c = 32'h0;
    c[31]    = m_bd;
    c[30]    = m_ti;
    c[15:8]  = m_ip();
    c[6:2]   = m_code;
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return c;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!rstn) begin
      m_base = COUNT_RESET; m_cyc = 0; m_count = COUNT_RESET;
      m_compare = 32'h0; m_status = 32'h0040_0000; m_epc = 32'h0;
      m_badv = 32'h0; m_code = 5'h0; m_bd = 1'b0; m_ti = 1'b0;
      m_sw = 2'b00; m_ip_hw = 5'h0; m_stage = 5'h0; m_irq = 1'b0;
    end else begin
      ipv  = m_ip();
      nirq = exception ? 1'b0
                       : ((|(ipv & m_status[15:8])) && m_status[0] && !m_status[1]);
      hwp  = 5'(hw_irq);
`ifdef CP0_IRQ_SYNC_EN
      m_ip_hw = m_stage;
      m_stage = hwp;
`else
      m_ip_hw = hwp;
`endif
      m_cyc++;
      clr = 1'b0;
      if (exception) begin
        if (!m_status[1]) begin
          m_epc = exc_pc;
          m_bd  = exc_bd;
        end
        m_status[1] = 1'b1;
        m_code = exc_code;
        if (exc_badvaddr_vld) m_badv = exc_badvaddr;
      end else if (eret) begin
        m_status[1] = 1'b0;
      end else if (wen) begin
        case (waddr)
          5'd9:  begin m_base = wdata; m_cyc = 0; end
          5'd11: begin m_compare = wdata; clr = 1'b1; end
          5'd12: m_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
          5'd13: m_sw = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
      cnt = m_base + 32'(m_cyc / TIMER_DIV);
      if (clr) m_ti = 1'b0;
      else if (cnt == m_compare) m_ti = 1'b1;
      m_count = cnt;
      m_irq   = nirq;
    end
  end

  // One compare process, every cycle once the model has been reset.
  always @(negedge clk) begin
    if (m_started) begin
      check("rdata_model", rdata, m_read(raddr));
      check("epc_out_model", epc_out, m_epc);
      check("status_exl_model", 32'(status_exl), 32'(m_status[1]));
      check("irq_pending_model", 32'(irq_pending), 32'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  logic [4:0] rot [0:6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
  int rot_i = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    raddr = rot[rot_i % 7];
    rot_i++;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, rdata, exp);
    $display("mfc0 reg %0d -> %08h", a, rdata);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
    $display("mtc0 reg %0d <= %08h", a, d);
  endtask

  initial begin
    rstn = 1'b0; wen = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr = 5'd0;
    exception = 1'b0; eret = 1'b0; exc_code = 5'h0; exc_pc = 32'h0;
    exc_bd = 1'b0; exc_badvaddr_vld = 1'b0; exc_badvaddr = 32'h0; hw_irq = '0;

    // Reset values, read while reset is held
    repeat (3) tick();
    rd("rst_badvaddr", 5'd8,  32'h0);
    rd("rst_count",    5'd9,  COUNT_RESET);
    rd("rst_compare",  5'd11, 32'h0);
    rd("rst_status",   5'd12, 32'h0040_0000);
    rd("rst_cause",    5'd13, 32'h0);
    rd("rst_epc",      5'd14, 32'h0);
    rd("rst_unmapped", 5'd5,  32'h0);
    check("rst_irq", 32'(irq_pending), 32'h0);
    rstn = 1'b1;

    // Timer match
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    repeat (9) tick();
    rd("count_9cyc", 5'd9, 32'd4);
    tick();
    rd("count_10cyc", 5'd9, 32'd5);
    rd("cause_ti", 5'd13, 32'h4000_8000);
    check("irq_before", 32'(irq_pending), 32'h0);
    tick();
    check("irq_timer", 32'(irq_pending), 32'h1);
    mtc0(5'd11, 32'd20);
    rd("cause_ti_clr", 5'd13, 32'h0);
    tick();
    check("irq_timer_clr", 32'(irq_pending), 32'h0);
    mtc0(5'd11, 32'h8000_0000);

    // Exception entry, then nested exception
    exception = 1'b1; exc_pc = 32'hBFC0_0100; exc_bd = 1'b1; exc_code = 5'h04;
    exc_badvaddr_vld = 1'b1; exc_badvaddr = 32'h1234_5679;
    tick();
    exception = 1'b0;
    $display("exception pc=%08h code=%0h", exc_pc, exc_code);
    rd("exc_epc", 5'd14, 32'hBFC0_0100);
    rd("exc_cause", 5'd13, 32'h8000_0010);
    rd("exc_badv", 5'd8, 32'h1234_5679);
    check("exc_exl", 32'(status_exl), 32'h1);
    check("exc_epc_out", epc_out, 32'hBFC0_0100);
    exception = 1'b1; exc_pc = 32'h0000_0040; exc_bd = 1'b0; exc_code = 5'h0C;
    exc_badvaddr_vld = 1'b0; exc_badvaddr = 32'hFFFF_0000;
    tick();
    exception = 1'b0;
    $display("nested exception pc=%08h code=%0h", exc_pc, exc_code);
    rd("nest_epc", 5'd14, 32'hBFC0_0100);
    rd("nest_cause", 5'd13, 32'h8000_0030);
    rd("nest_badv", 5'd8, 32'h1234_5679);

    eret = 1'b1;
    tick();
    eret = 1'b0;
    $display("eret");
    check("eret_exl", 32'(status_exl), 32'h0);

    // exception + eret + wen together: exception wins
    exception = 1'b1; eret = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 32'h0;
    exc_pc = 32'h0000_0100; exc_bd = 1'b0; exc_code = 5'h00;
    tick();
    exception = 1'b0; eret = 1'b0; wen = 1'b0;
    $display("exception+eret+mtc0 status");
    rd("prio_status", 5'd12, 32'h0040_8003);
    rd("prio_epc", 5'd14, 32'h0000_0100);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // hw_irq[0] -> irq_pending latency
    mtc0(5'd12, 32'h0000_0401);
    hw_irq = 5'b00001;
    tick();
    check("hw_irq_lat1", 32'(irq_pending), 32'h0);
    tick();
`ifdef CP0_IRQ_SYNC_EN
    check("hw_irq_lat2", 32'(irq_pending), 32'h0);
    tick();
`endif
    check("hw_irq_rise", 32'(irq_pending), 32'h1);
    mtc0(5'd12, 32'h0000_0403);
    check("hw_irq_exl_edge", 32'(irq_pending), 32'h1);
    tick();
    check("hw_irq_exl_drop", 32'(irq_pending), 32'h0);
    hw_irq = '0;
    mtc0(5'd12, 32'h0000_0401);
    repeat (4) tick();
    check("hw_irq_idle", 32'(irq_pending), 32'h0);

    // Cause write: only IP[1:0] take
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_write", 5'd13, 32'h0000_0300);
    mtc0(5'd12, 32'h0000_0301);
    check("sw_irq_edge", 32'(irq_pending), 32'h0);
    tick();
    check("sw_irq", 32'(irq_pending), 32'h1);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd("count_load", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("count_hold", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("count_wrap", 5'd9, 32'h0);

    // Reset mid-operation with a pending write
    rstn = 1'b0; wen = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    wen = 1'b0;
    $display("reset with pending mtc0 epc");
    rd("mid_rst_epc", 5'd14, 32'h0);
    rd("mid_rst_status", 5'd12, 32'h0040_0000);
    check("mid_rst_irq", 32'(irq_pending), 32'h0);
    rstn = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
